boot_loader: RTL
================

// Module: boot_loader
// PURPOSE
//   Boot-side driver for the core's fetch/reset interface (NucleoTop clk, pc_in, reset_pc).
//   Receives a program as a byte stream over a valid/ready handshake.
//   Packs the bytes big-endian into 32-bit instruction words and writes them into
//   instruction memory.
//   While loading it holds the core in reset. Afterwards it presents the entry PC and
//   releases reset_pc, replacing the hand-driven reset/pc_in sequence of a bench.
// PARAMETERS
//   ADDRESS_INSTRUCCION  8   width of pc_in / imem_addr; imem depth = 2**ADDRESS_INSTRUCCION words
//   DATA_WIDTH           32  instruction word width (fixed at 4 bytes)
//   RELEASE_CYCLES       2   cycles reset_pc stays high with pc_in valid, after the last write
// PORTS
//   clk         in   1      system clock, rising edge
//   reset_n     in   1      synchronous, active-low reset
//   start       in   1      1-cycle load request; sampled in IDLE and RUN only
//   len_words   in   A+1    number of words to load, sampled with start
//   entry_pc    in   A      PC handed to the core, sampled with start
//   in_valid    in   1      byte-stream valid
//   in_ready    out  1      byte-stream ready
//   in_byte     in   8      byte-stream data, MSB byte of each word first
//   imem_we     out  1      instruction-memory write strobe, 1 cycle per word
//   imem_addr   out  A      word address of the write
//   imem_wdata  out  32     word being written
//   reset_pc    out  1      active-high reset to the core
//   pc_in       out  A      start PC to the core
//   busy        out  1      high in LOAD and RELEASE
//   done        out  1      high in RUN
//   error       out  1      sticky; cleared by the next accepted start or by reset
// BEHAVIOUR
//   Reset (reset_n=0 at a rising edge): state=IDLE; reset_pc=1; all other outputs 0.
//   States and transitions:
//     IDLE    : reset_pc=1, in_ready=0.
//               start & len_words > 2**A           -> error=1, stay IDLE.
//               start & len_words==0               -> RELEASE.
//               start otherwise                    -> LOAD; word_cnt=0, byte_cnt=0, error=0.
//     LOAD    : in_ready=1 for every cycle, including the write cycles.
//               A byte is accepted at an edge where in_valid & in_ready; it shifts into
//               wbuf = {wbuf[23:0], in_byte}.
//               Edge of the 4th byte: registers imem_we=1, imem_addr=word_cnt, and
//               imem_wdata = the full word; word_cnt increments at the same edge.
//               imem_we falls at the next edge, so a write lasts exactly 1 cycle and
//               follows the 4th byte with 1-cycle latency.
//               Edge of the 4th byte of word len_words-1 -> RELEASE; in_ready=0 from
//               that edge onward.
//               start in LOAD is ignored.
//     RELEASE : in_ready=0, reset_pc=1, pc_in=entry_pc; lasts RELEASE_CYCLES cycles,
//               then -> RUN.
//     RUN     : reset_pc=0, pc_in=entry_pc (held), done=1.
//               start with a valid len_words -> LOAD; reset_pc=1 and done=0 at that same
//               edge (reload).
//               start with an invalid len_words -> error=1, stay in RUN.
//   Handshake: in_ready never depends on in_valid in the same cycle.
//     in_valid while in_ready=0 -> byte is dropped and has no effect.
//   Arithmetic: word_cnt is A+1 bits; imem_addr = word_cnt[A-1:0].
//     len_words == 2**A fills the memory exactly; the address does not wrap inside a load.
//   Reset mid-LOAD or mid-RELEASE: the partial word is discarded.
//     Already-written words are not cleared.
//     reset_pc returns to 1 at the reset edge.
//   Stalls: gaps in in_valid are allowed anywhere, including between the bytes of one word.
// TESTING
//   1. Reset, then start, len=2, entry=0x10; stream 12 34 56 78 AA BB CC DD ->
//      we@addr0=0x12345678 and we@addr1=0xAABBCCDD, each 1 cycle after its 4th byte.
//      reset_pc falls 2 cycles after the final RELEASE entry; pc_in=0x10; done=1.
//   2. in_valid toggling 1-0-1 inside a word, plus in_valid pulses in IDLE ->
//      identical memory contents; the IDLE bytes are ignored.
//   3. start with len=257 (A=8) -> error=1, stay IDLE, reset_pc=1, no writes.
//      Then start with len=0 -> RELEASE/RUN with no writes, error cleared.
//   4. In RUN, start with len=1 and stream 00 00 00 0C ->
//      reset_pc=1 at the start edge; we@addr0=0x0000000C; core released again.
//   5. reset_n=0 after 2 bytes of word 1 -> IDLE, reset_pc=1, no further writes.
//      A following load starts again at addr0.
//   6. len=256 -> 256 writes at addr 0..255 with no wrap; start pulses during LOAD are ignored.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: receives a program as a byte stream and writes it into the core's
// instruction memory. Bytes are packed big-endian into 32-bit words. The core is
// held in reset while the program loads. After loading, the loader presents the
// entry PC and releases reset_pc.
module boot_loader #(
  parameter int ADDRESS_INSTRUCCION = 8,
  parameter int DATA_WIDTH          = 32,
  parameter int RELEASE_CYCLES      = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [ADDRESS_INSTRUCCION:0]   len_words,
  input  logic [ADDRESS_INSTRUCCION-1:0] entry_pc,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_byte,
  output logic                           imem_we,
  output logic [ADDRESS_INSTRUCCION-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]          imem_wdata,
  output logic                           reset_pc,
  output logic [ADDRESS_INSTRUCCION-1:0] pc_in,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int A     = ADDRESS_INSTRUCCION;
  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  // Largest legal load: the whole memory, 2**A words.
  localparam logic [A:0] MAX_WORDS = {1'b1, {A{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [A:0]            word_cnt_q, word_cnt_d;
  logic [A:0]            len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-9:0] wbuf_q, wbuf_d;
  logic [REL_W-1:0]      rel_cnt_q, rel_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [A-1:0]          imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                  reset_pc_q, reset_pc_d;
  logic [A-1:0]          pc_in_q, pc_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [A:0]            word_cnt_inc;

  assign word_cnt_inc = word_cnt_q + 1'b1;

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    // NOTE: every _d gets a default first, so no path leaves it unassigned (no latch).
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    wbuf_d       = wbuf_q;
    rel_cnt_d    = rel_cnt_q;
    in_ready_d   = in_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    reset_pc_d   = reset_pc_q;
    pc_in_d      = pc_in_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (len_words > MAX_WORDS) begin
            // Reject the request. The core keeps running if it was already released.
            error_d = 1'b1;
          end else begin
            error_d    = 1'b0;
            pc_in_d    = entry_pc;
            len_d      = len_words;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            reset_pc_d = 1'b1;
            done_d     = 1'b0;
            busy_d     = 1'b1;
            if (len_words == '0) begin
              state_d   = S_RELEASE;
              rel_cnt_d = '0;
            end else begin
              state_d    = S_LOAD;
              in_ready_d = 1'b1;
            end
          end
        end
      end

      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          wbuf_d     = {wbuf_q[DATA_WIDTH-17:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[A-1:0];
            imem_wdata_d = {wbuf_q, in_byte};
            word_cnt_d   = word_cnt_inc;
            if (word_cnt_inc == len_q) begin
              state_d    = S_RELEASE;
              in_ready_d = 1'b0;
              rel_cnt_d  = '0;
            end
          end
        end
      end

      S_RELEASE: begin
        if (rel_cnt_q == REL_W'(RELEASE_CYCLES - 1)) begin
          state_d    = S_RUN;
          reset_pc_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs. Synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
    if (!reset_n) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      wbuf_q       <= '0;
      rel_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      reset_pc_q   <= 1'b1;
      pc_in_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      wbuf_q       <= wbuf_d;
      rel_cnt_q    <= rel_cnt_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      reset_pc_q   <= reset_pc_d;
      pc_in_q      <= pc_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign reset_pc   = reset_pc_q;
  assign pc_in      = pc_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
